// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared widths, zero-register constant and flat-bus slicing helpers
package id_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 5;
    localparam int ZERO_REG_ADDR = 0;

    function automatic int unsigned lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// rtl/id_fwd_mux.sv - single-port priority forwarding selector with hazard flag
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int NUM_FWD  = 3,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                      valid,
    input  logic                      rd_use,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         gpr_data,
    input  logic [NUM_FWD-1:0]        fwd_en,
    input  logic [NUM_FWD-1:0]        fwd_we_,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_dst,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    output logic [DATA_W-1:0]         opnd,
    output logic                      hazard
);

    logic              hit;
    logic              sel_pend;
    logic [DATA_W-1:0] sel_data;

    // Walk oldest to youngest so the youngest matching stage is the last (winning) assignment
    always_comb begin
        hit      = 1'b0;
        sel_pend = 1'b0;
        sel_data = gpr_data;
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            if (fwd_en[j] && !fwd_we_[j] &&
                fwd_dst[lsb(j, ADDR_W) +: ADDR_W] == addr) begin
                hit      = 1'b1;
                sel_pend = fwd_pend[j];
                sel_data = fwd_data[lsb(j, DATA_W) +: DATA_W];
            end
        end
        if (ZERO_REG != 0 && addr == ADDR_W'(ZERO_REG_ADDR)) begin
            hit      = 1'b0;
            sel_pend = 1'b0;
            sel_data = '0;
        end
        opnd   = sel_data;
        hazard = valid & rd_use & hit & sel_pend;
    end

endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - decode operand resolution, hazard detect and ID/EX register
module id_operand_stage
    import id_pkg::*;
#(
    parameter int NUM_RD   = 2,
    parameter int NUM_FWD  = 3,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CTRL_W   = 64,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    input  logic [NUM_RD-1:0]         rd_use,
    input  logic [NUM_RD*DATA_W-1:0]  gpr_rd_data,
    input  logic [NUM_FWD-1:0]        fwd_en,
    input  logic [NUM_FWD-1:0]        fwd_we_,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_dst,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      cnt_clr,
    output logic                      ld_hazard,
    output logic                      out_valid,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NUM_RD*DATA_W-1:0]  out_opnd,
    output logic [CNT_W-1:0]          hazard_cnt
);

    logic [NUM_RD*DATA_W-1:0] resolved;
    logic [NUM_RD-1:0]        port_hazard;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        id_fwd_mux #(
            .NUM_FWD (NUM_FWD),
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_mux (
            .valid   (in_valid),
            .rd_use  (rd_use[i]),
            .addr    (rd_addr[lsb(i, ADDR_W) +: ADDR_W]),
            .gpr_data(gpr_rd_data[lsb(i, DATA_W) +: DATA_W]),
            .fwd_en  (fwd_en),
            .fwd_we_ (fwd_we_),
            .fwd_dst (fwd_dst),
            .fwd_data(fwd_data),
            .fwd_pend(fwd_pend),
            .opnd    (resolved[lsb(i, DATA_W) +: DATA_W]),
            .hazard  (port_hazard[i])
        );
    end

    assign ld_hazard = |port_hazard;

    // ID/EX register: flush beats stall beats hazard bubble beats normal capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_opnd  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (stall) begin
            out_valid <= out_valid;
        end else if (ld_hazard) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else begin
            out_valid <= in_valid;
            out_ctrl  <= in_ctrl;
            out_opnd  <= resolved;
        end
    end

    // Saturating count of bubbles actually inserted; clear has priority over counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hazard_cnt <= '0;
        end else if (cnt_clr) begin
            hazard_cnt <= '0;
        end else if (ld_hazard && !stall && !flush && hazard_cnt != '1) begin
            hazard_cnt <= hazard_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - scoreboard bench for id_operand_stage
module tb_id_operand_stage;

    localparam int NUM_RD  = 2;
    localparam int NUM_FWD = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CTRL_W  = 64;
    localparam int CNT_W   = 4;

    logic                      clk;
    logic                      reset;
    logic                      in_valid;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD-1:0]         rd_use;
    logic [NUM_RD*DATA_W-1:0]  gpr_rd_data;
    logic [NUM_FWD-1:0]        fwd_en;
    logic [NUM_FWD-1:0]        fwd_we_;
    logic [NUM_FWD*ADDR_W-1:0] fwd_dst;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    logic [NUM_FWD-1:0]        fwd_pend;
    logic                      stall;
    logic                      flush;
    logic                      cnt_clr;
    logic                      ld_hazard;
    logic                      out_valid;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [NUM_RD*DATA_W-1:0]  out_opnd;
    logic [CNT_W-1:0]          hazard_cnt;

    id_operand_stage #(
        .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .CTRL_W(CTRL_W), .CNT_W(CNT_W), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .rd_addr(rd_addr), .rd_use(rd_use), .gpr_rd_data(gpr_rd_data),
        .fwd_en(fwd_en), .fwd_we_(fwd_we_), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .fwd_pend(fwd_pend), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .ld_hazard(ld_hazard), .out_valid(out_valid), .out_ctrl(out_ctrl),
        .out_opnd(out_opnd), .hazard_cnt(hazard_cnt)
    );

    typedef struct {
        string             name;
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] op0;
        logic [DATA_W-1:0] op1;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: after each rising edge compare the registered outputs with the oldest expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".valid"}, 64'(out_valid), 64'(e.valid));
            check({e.name, ".ctrl"},  out_ctrl, e.ctrl);
            check({e.name, ".op0"},   64'(out_opnd[0 +: DATA_W]), 64'(e.op0));
            check({e.name, ".op1"},   64'(out_opnd[DATA_W +: DATA_W]), 64'(e.op1));
            check({e.name, ".cnt"},   64'(hazard_cnt), 64'(e.cnt));
        end
    end

    task automatic set_idle();
        in_valid    = 1'b0;
        in_ctrl     = '0;
        rd_addr     = '0;
        rd_use      = '0;
        gpr_rd_data = '0;
        fwd_en      = '0;
        fwd_we_     = '1;
        fwd_dst     = '0;
        fwd_data    = '0;
        fwd_pend    = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] g0, input logic [31:0] g1, input logic [1:0] u);
        rd_addr     = {a1, a0};
        gpr_rd_data = {g1, g0};
        rd_use      = u;
    endtask

    // EX stage holds a pending load to r7 that port 1 consumes
    task automatic set_load_hazard(input logic [63:0] ctrl);
        in_valid = 1'b1;
        in_ctrl  = ctrl;
        set_rd(5'd3, 5'd7, 32'h11, 32'h22, 2'b10);
        fwd_en   = 3'b001;
        fwd_we_  = 3'b110;
        fwd_dst  = {5'd0, 5'd0, 5'd7};
        fwd_data = {32'h0, 32'h0, 32'h77};
        fwd_pend = 3'b001;
    endtask

    // Inputs are already applied; check the combinational hazard, queue the post-edge state
    task automatic cycle(input string name, input logic hz, input logic v, input logic [63:0] c,
                         input logic [31:0] o0, input logic [31:0] o1, input logic [3:0] cnt);
        exp_t e;
        #1;
        check({name, ".ld_hazard"}, 64'(ld_hazard), 64'(hz));
        e.name = name; e.valid = v; e.ctrl = c; e.op0 = o0; e.op1 = o1; e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".valid"}, 64'(out_valid), 64'd0);
        check({name, ".ctrl"},  out_ctrl, 64'd0);
        check({name, ".opnd"},  out_opnd, 64'd0);
        check({name, ".cnt"},   64'(hazard_cnt), 64'd0);
    endtask

    initial begin
        int guard;
        set_idle();
        reset = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        set_idle(); in_valid = 1'b1; in_ctrl = 64'hC0DE_0000_0000_0001;
        set_rd(5'd3, 5'd4, 32'h11, 32'h22, 2'b11);
        cycle("nomatch", 1'b0, 1'b1, 64'hC0DE_0000_0000_0001, 32'h11, 32'h22, 4'd0);

        set_idle(); in_valid = 1'b1; in_ctrl = 64'h2;
        set_rd(5'd5, 5'd4, 32'h55, 32'h22, 2'b11);
        fwd_en = 3'b011; fwd_we_ = 3'b100; fwd_dst = {5'd0, 5'd5, 5'd5};
        fwd_data = {32'h0, 32'hBBBB, 32'hAAAA};
        cycle("prio_ex", 1'b0, 1'b1, 64'h2, 32'hAAAA, 32'h22, 4'd0);

        fwd_en = 3'b010; in_ctrl = 64'h3;
        cycle("prio_mem", 1'b0, 1'b1, 64'h3, 32'hBBBB, 32'h22, 4'd0);

        set_idle(); set_load_hazard(64'h4);
        cycle("loaduse", 1'b1, 1'b0, 64'h0, 32'hBBBB, 32'h22, 4'd1);

        set_idle(); set_load_hazard(64'h5); rd_use = 2'b00;
        cycle("loaduse_unused", 1'b0, 1'b1, 64'h5, 32'h11, 32'h77, 4'd1);

        set_idle(); in_valid = 1'b1; in_ctrl = 64'h6;
        set_rd(5'd9, 5'd4, 32'h0, 32'h22, 2'b01);
        fwd_en = 3'b011; fwd_we_ = 3'b100; fwd_dst = {5'd0, 5'd9, 5'd9};
        fwd_data = {32'h0, 32'h98, 32'h99}; fwd_pend = 3'b001;
        cycle("young_pending", 1'b1, 1'b0, 64'h0, 32'h11, 32'h77, 4'd2);

        set_idle(); in_valid = 1'b1; in_ctrl = 64'h7;
        set_rd(5'd0, 5'd0, 32'h55, 32'h66, 2'b11);
        fwd_en = 3'b001; fwd_we_ = 3'b110; fwd_dst = '0;
        fwd_data = {32'h0, 32'h0, 32'hDEAD}; fwd_pend = 3'b001;
        cycle("zero_reg", 1'b0, 1'b1, 64'h7, 32'h0, 32'h0, 4'd2);

        set_idle(); set_load_hazard(64'h8); flush = 1'b1; stall = 1'b1;
        cycle("flush_stall_hz", 1'b1, 1'b0, 64'h0, 32'h0, 32'h0, 4'd2);

        set_idle(); in_valid = 1'b1; in_ctrl = 64'h9;
        set_rd(5'd3, 5'd4, 32'h11, 32'h22, 2'b11);
        cycle("capture", 1'b0, 1'b1, 64'h9, 32'h11, 32'h22, 4'd2);

        set_idle(); stall = 1'b1; in_ctrl = 64'hA; set_rd(5'd3, 5'd4, 32'hE1, 32'hE2, 2'b11);
        cycle("stall1", 1'b0, 1'b1, 64'h9, 32'h11, 32'h22, 4'd2);
        set_idle(); set_load_hazard(64'hA); stall = 1'b1;
        cycle("stall2_hz", 1'b1, 1'b1, 64'h9, 32'h11, 32'h22, 4'd2);
        set_idle(); stall = 1'b1; in_valid = 1'b1; in_ctrl = 64'hA;
        cycle("stall3", 1'b0, 1'b1, 64'h9, 32'h11, 32'h22, 4'd2);

        set_idle(); flush = 1'b1; in_valid = 1'b1; in_ctrl = 64'hB;
        cycle("flush", 1'b0, 1'b0, 64'h0, 32'h11, 32'h22, 4'd2);

        for (int k = 1; k <= 20; k++) begin
            logic [3:0] exp_cnt;
            exp_cnt = (2 + k > 15) ? 4'hF : 4'(2 + k);
            set_idle(); set_load_hazard(64'hF0 + 64'(k));
            cycle($sformatf("sat%0d", k), 1'b1, 1'b0, 64'h0, 32'h11, 32'h22, exp_cnt);
        end

        set_idle(); set_load_hazard(64'hD); cnt_clr = 1'b1;
        cycle("clr_with_hz", 1'b1, 1'b0, 64'h0, 32'h11, 32'h22, 4'd0);

        set_idle(); set_load_hazard(64'hD);
        cycle("count_after_clr", 1'b1, 1'b0, 64'h0, 32'h11, 32'h22, 4'd1);

        set_idle(); in_valid = 1'b1; in_ctrl = 64'hC;
        set_rd(5'd3, 5'd4, 32'h33, 32'h44, 2'b11);
        cycle("pre_reset", 1'b0, 1'b1, 64'hC, 32'h33, 32'h44, 4'd1);

        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        cycle("post_reset", 1'b0, 1'b0, 64'h0, 32'h0, 32'h0, 4'd0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
